disp_mode_ctrl: RTL
===================

Name: disp_mode_ctrl

Overview:
- Owns the `pkg_disp::t_sync` parameter set that drives the HDMI sync/timing generator.
- Accepts video-mode change requests over a valid/ready handshake and holds the new request until end of frame. It then swaps the timing parameters exactly on the frame wrap.
- Asserts `mute` from request acceptance until a programmable number of complete frames have run in the new mode.
- Sits between the system/control logic and the sync generator; feeds back on the generator's x/y counters.

Parameters:
- `MUTE_FRAMES`, 2, number of complete frames in the new mode during which `mute` stays high; 0 is legal.
- `DEF_MODE`, 0, index into `pkg_disp::MODES` loaded at reset.
- `TIMEOUT_CYC`, 4194304, maximum cycles spent waiting for end of frame before the mode is applied anyway.

Ports:
- `clk` in 1: pixel clock, same clock as the sync generator.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: mode-change request valid.
- `req_mode` in `MODE_W`: requested index into `pkg_disp::MODES`.
- `req_ready` out 1: high only in IDLE.
- `x` in 11: horizontal counter from the sync generator.
- `y` in 11: vertical counter from the sync generator.
- `sp` out `pkg_disp::t_sync`: registered timing parameters to the sync generator.
- `cur_mode` out `MODE_W`: index of the mode currently on `sp`.
- `mute` out 1: downstream pixel source drives black / suppresses data while high.
- `done` out 1: one-cycle pulse when a request completes.
- `err` out 1: one-cycle pulse when a request is rejected.

Behaviour:
- Reset (`rst`=1 at a rising edge):
  - `sp` <= `MODES[DEF_MODE]`, `cur_mode` <= `DEF_MODE`.
  - State <= MUTE, `mute` = 1, frame count = 0, `done` = 0, `err` = 0, `req_ready` = 0.
  - Reset mid-operation aborts any pending request with no `done`/`err` pulse.
- Per-mode totals, all computed in 12 bits:
  - htot = horz_pix + horz_front_porch + horz_sync + horz_back_porch.
  - vtot = the same sum over the vertical fields.
  - Table entries must satisfy htot ≤ 2048 and vtot ≤ 2048; this is checked by an elaboration assertion.
- `eof` = (x == htot-1) && (y == vtot-1), always evaluated against the current `sp`.
- States: IDLE, WAIT_EOF, MUTE.
- IDLE:
  - `req_ready` = 1, `mute` = 0.
  - On `req_valid` with `req_mode` ≥ `N_MODES`: `err` pulses the next cycle; stay in IDLE; `sp` unchanged.
  - On `req_valid` with `req_mode` == `cur_mode`: `done` pulses the next cycle; stay in IDLE; no mute.
  - Otherwise: latch `req_mode`; go to WAIT_EOF; `mute` = 1 from the next cycle; clear the timeout counter.
- WAIT_EOF:
  - `req_ready` = 0; new requests are ignored (not queued).
  - On the `eof` cycle: `sp` <= `MODES[latched]` and `cur_mode` <= latched at that edge, so the sync generator's wrap to (0,0) and the new parameters coincide. Then go to MUTE with frame count = 0.
  - If the timeout counter reaches `TIMEOUT_CYC`-1 before `eof`: apply the mode the same way and go to MUTE. The timeout is not an error and raises no `err` pulse.
- MUTE:
  - Increment the frame count on each `eof` using the new `sp`.
  - When the count reaches `MUTE_FRAMES`: go to IDLE; `mute` drops and `done` pulses in the same cycle, the cycle after the final `eof`.
  - If `MUTE_FRAMES` == 0: leave MUTE on the cycle after entry with the `done` pulse.
  - After reset, MUTE behaves identically except that no `done` is issued.
- `sp` changes only on the applying edge or on reset, never mid-frame.
- `x`/`y` values beyond the totals (e.g. glitched input) are never matched as `eof`; the timeout covers this case.

Decomposition:
- `pkg_disp` gets:
  - `N_MODES` = 4 and `MODE_W` = 2.
  - The constant array `MODES[N_MODES]` of `t_sync`: 640x480, 800x600, 1024x768, 1280x720.
  - Functions `htot(t_sync)` and `vtot(t_sync)` returning 12 bits.
  - The enum `t_mode_st` {IDLE, WAIT_EOF, MUTE}.
- Sub-module `disp_eof_det`: combinational end-of-frame compare of x/y against the totals of a `t_sync` input. It is reused by other blocks that need frame boundaries.

Test Plan:
- Reset with `DEF_MODE`=0 → `sp` = 640x480 (htot 800, vtot 525). `mute`=1 for exactly 2 frames, i.e. it falls the cycle after the 2nd `eof`. `req_ready` rises at the same cycle; no `done`.
- In IDLE, request mode 3 at x=100, y=10 → `req_ready` drops and `mute`=1 next cycle. `sp` stays 640x480 until the edge after x=799, y=524, where `sp`=1280x720 and `cur_mode`=3. `done` pulses after 2 further frames of htot 1650 × vtot 750.
- Request `req_mode`=`cur_mode` → single `done` pulse next cycle; `mute` stays 0; `sp` unchanged.
- Request mode index 5 with `MODE_W` overridden to 3 → `err` pulse next cycle, state IDLE, `sp` unchanged. Also: `req_valid` held in WAIT_EOF is not accepted.
- Freeze x at 0 after accepting a request, `TIMEOUT_CYC`=1000 → `sp` switches after exactly 1000 cycles in WAIT_EOF; no `err`.
- Assert `rst` during WAIT_EOF → `sp` returns to `MODES[DEF_MODE]`, state MUTE, no `done`/`err` pulse.

Source files
------------

// File: rtl/pkg_disp.sv
// Shared display-timing types: the sync parameter set, the supported mode table
// and the mode-controller state encoding.
package pkg_disp;

  localparam int unsigned N_MODES = 4;
  localparam int unsigned MODE_W  = 2;

  typedef struct packed {
    logic [11:0] horz_pix;
    logic [11:0] horz_front_porch;
    logic [11:0] horz_sync;
    logic [11:0] horz_back_porch;
    logic        horz_pol;
    logic [11:0] vert_pix;
    logic [11:0] vert_front_porch;
    logic [11:0] vert_sync;
    logic [11:0] vert_back_porch;
    logic        vert_pol;
  } t_sync;

  // Polarity: 1 = active-high sync pulse.
  localparam t_sync MODES [N_MODES] = '{
    '{horz_pix: 12'd640,  horz_front_porch: 12'd16,  horz_sync: 12'd96,
      horz_back_porch: 12'd48,  horz_pol: 1'b0,
      vert_pix: 12'd480,  vert_front_porch: 12'd10,  vert_sync: 12'd2,
      vert_back_porch: 12'd33,  vert_pol: 1'b0},
    '{horz_pix: 12'd800,  horz_front_porch: 12'd40,  horz_sync: 12'd128,
      horz_back_porch: 12'd88,  horz_pol: 1'b1,
      vert_pix: 12'd600,  vert_front_porch: 12'd1,   vert_sync: 12'd4,
      vert_back_porch: 12'd23,  vert_pol: 1'b1},
    '{horz_pix: 12'd1024, horz_front_porch: 12'd24,  horz_sync: 12'd136,
      horz_back_porch: 12'd160, horz_pol: 1'b0,
      vert_pix: 12'd768,  vert_front_porch: 12'd3,   vert_sync: 12'd6,
      vert_back_porch: 12'd29,  vert_pol: 1'b0},
    '{horz_pix: 12'd1280, horz_front_porch: 12'd110, horz_sync: 12'd40,
      horz_back_porch: 12'd220, horz_pol: 1'b1,
      vert_pix: 12'd720,  vert_front_porch: 12'd5,   vert_sync: 12'd5,
      vert_back_porch: 12'd20,  vert_pol: 1'b1}
  };

  function automatic logic [11:0] htot(input t_sync s);
    return s.horz_pix + s.horz_front_porch + s.horz_sync + s.horz_back_porch;
  endfunction

  function automatic logic [11:0] vtot(input t_sync s);
    return s.vert_pix + s.vert_front_porch + s.vert_sync + s.vert_back_porch;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EOF,
    MUTE
  } t_mode_st;

endpackage

// File: rtl/disp_eof_det.sv
// Combinational end-of-frame detect: true on the last pixel of the last line of
// the timing described by sp_i. Out-of-range counters never match.
module disp_eof_det
  import pkg_disp::*;
(
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  input  t_sync       sp_i,
  output logic        eof_o
);

  logic [11:0] htot_m1;
  logic [11:0] vtot_m1;

  always_comb begin
    htot_m1 = htot(sp_i) - 12'd1;
    vtot_m1 = vtot(sp_i) - 12'd1;
    eof_o   = ({1'b0, x_i} == htot_m1) && ({1'b0, y_i} == vtot_m1);
  end

endmodule

// File: rtl/disp_mode_ctrl.sv
// Video mode controller: accepts mode requests, swaps the sync parameters on the
// frame wrap (or after a timeout) and mutes output until the new mode has settled.
module disp_mode_ctrl
  import pkg_disp::*;
#(
  parameter int unsigned MUTE_FRAMES = 2,
  parameter int unsigned DEF_MODE    = 0,
  parameter int unsigned TIMEOUT_CYC = 4194304,
  parameter int unsigned MODE_W      = pkg_disp::MODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  output t_sync             sp,
  output logic [MODE_W-1:0] cur_mode,
  output logic              mute,
  output logic              done,
  output logic              err
);

  localparam int unsigned IdxW   = pkg_disp::MODE_W;
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned FrameW = (MUTE_FRAMES < 2) ? 1 : $clog2(MUTE_FRAMES + 1);

  localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(MUTE_FRAMES - 1);
  localparam logic [IdxW-1:0]   DefIdx    = IdxW'(DEF_MODE);

  for (genvar i = 0; i < N_MODES; i++) begin : g_mode_chk
    if (htot(MODES[i]) > 12'd2048 || vtot(MODES[i]) > 12'd2048) begin : g_bad_mode
      $error("disp_mode_ctrl: mode %0d totals exceed 2048", i);
    end
  end

  if (DEF_MODE >= N_MODES || MODE_W < IdxW || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("disp_mode_ctrl: illegal parameterisation");
  end

  // Only called with indices already range-checked against N_MODES.
  function automatic t_sync mode_sp(input logic [MODE_W-1:0] m);
    return MODES[IdxW'(m)];
  endfunction

  t_mode_st          state_q, state_d;
  t_sync             sp_q, sp_d;
  logic [MODE_W-1:0] cur_q, cur_d;
  logic [MODE_W-1:0] pend_q, pend_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [FrameW-1:0] fcnt_q, fcnt_d;
  logic              owed_q, owed_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              eof;

  disp_eof_det u_eof_det (
    .x_i   (x),
    .y_i   (y),
    .sp_i  (sp_q),
    .eof_o (eof)
  );

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    fcnt_d  = fcnt_q;
    owed_d  = owed_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (32'(req_mode) >= N_MODES) begin
            err_d = 1'b1;
          end else if (req_mode == cur_q) begin
            done_d = 1'b1;
          end else begin
            pend_d  = req_mode;
            tmo_d   = '0;
            owed_d  = 1'b1;
            state_d = WAIT_EOF;
          end
        end
      end

      WAIT_EOF: begin
        // Swapping on the eof edge lines the new parameters up with the wrap to (0,0).
        if (eof || tmo_q == TmoLast) begin
          sp_d    = mode_sp(pend_q);
          cur_d   = pend_q;
          fcnt_d  = '0;
          state_d = MUTE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      MUTE: begin
        if (MUTE_FRAMES == 0) begin
          state_d = IDLE;
          done_d  = owed_q;
          owed_d  = 1'b0;
        end else if (eof) begin
          if (fcnt_q == FrameLast) begin
            state_d = IDLE;
            done_d  = owed_q;
            owed_d  = 1'b0;
          end else begin
            fcnt_d = fcnt_q + FrameW'(1);
          end
        end
      end

      default: state_d = MUTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUTE;
      sp_q    <= MODES[DefIdx];
      cur_q   <= MODE_W'(DEF_MODE);
      pend_q  <= '0;
      tmo_q   <= '0;
      fcnt_q  <= '0;
      owed_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      fcnt_q  <= fcnt_d;
      owed_q  <= owed_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mute      = (state_q != IDLE);
  assign sp        = sp_q;
  assign cur_mode  = cur_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
